peripheral_dbg_pu_or1k_burst: RTL and testbench
===============================================

PERIPHERAL_DBG_PU_OR1K_BURST -- requirements
Module: peripheral_dbg_pu_or1k_burst

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter LEN_W, default 16, burst length field width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, read FIFO depth, power of two, >=2.
REQ-005 SHALL have parameter TIMEOUT, default 255, max cycles per access without ack; 0 disables timeout.
REQ-006 SHALL have one clock and asynchronous active-high reset: cpu_clk_i  in  1  clock; rst_i  in  1  async active-high reset.
REQ-007 SHALL have: cmd_valid_i  in  1  command offered; cmd_ready_o  out  1  command accepted when both high.
REQ-008 SHALL have: cmd_addr_i  in  AW  start address; cmd_we_i  in  1  1=write; cmd_len_i  in  LEN_W  words minus one; cmd_incr_i  in  1  auto-increment address.
REQ-009 SHALL have: wdata_valid_i  in  1; wdata_ready_o  out  1; wdata_i  in  DW  write word stream.
REQ-010 SHALL have: rdata_valid_o  out  1; rdata_ready_i  in  1; rdata_o  out  DW  read word stream (FIFO head).
REQ-011 SHALL have: busy_o  out  1  burst in progress; done_o  out  1  one-cycle end-of-burst pulse; err_o  out  1  sticky timeout flag.
REQ-012 SHALL have SPR bus: cpu_addr_o  out  AW; cpu_data_o  out  DW; cpu_data_i  in  DW; cpu_stb_o  out  1; cpu_we_o  out  1; cpu_ack_i  in  1.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, ACCESS.
REQ-014 cmd_ready_o SHALL equal (state==IDLE); on acceptance addr, we, incr latch, remaining count := cmd_len_i, err_o clears, next state ISSUE.
REQ-015 In ISSUE, write: wdata_ready_o=1; on wdata handshake word latches to cpu_data_o register, next ACCESS.
REQ-016 In ISSUE, read: next ACCESS only when FIFO not full; else stay ISSUE.
REQ-017 cpu_stb_o SHALL be 1 exactly while state==ACCESS; cpu_addr_o/cpu_we_o/cpu_data_o stable throughout ACCESS.
REQ-018 Ack in ACCESS (incl. first cycle) completes the word: read pushes cpu_data_i into FIFO same edge; if incr, addr += 1 modulo 2^AW, else unchanged.
REQ-019 After ack: remaining==0 -> IDLE with done_o=1 next cycle; else remaining -= 1, next ISSUE.
REQ-020 Minimum word latency: accept -> ISSUE -> ACCESS, stb on 2nd cycle after acceptance with wdata/FIFO space available.
REQ-021 Access counter counts ACCESS cycles; if TIMEOUT!=0 and counter reaches TIMEOUT without ack: stb drops, err_o=1, burst aborted, IDLE, done_o pulses, no FIFO push.
REQ-022 Ack coinciding with timeout expiry SHALL count as ack, no error.
REQ-023 cpu_ack_i outside ACCESS SHALL be ignored.
REQ-024 FIFO SHALL allow simultaneous push and pop at any fill level including full (pop frees slot same edge); rdata_valid_o = not empty; FIFO contents persist after done_o.
REQ-025 busy_o SHALL be (state!=IDLE).

Reset
REQ-026 On rst_i: state IDLE, cpu_stb_o 0, cpu_we_o 0, cpu_addr_o 0, cpu_data_o 0, done_o 0, err_o 0, FIFO empty (rdata_valid_o 0, rdata_o 0), counters 0, cmd_ready_o 1.
REQ-027 Reset mid-burst SHALL drop stb asynchronously and discard the burst and FIFO contents.

Structure
REQ-028 Package peripheral_dbg_pu_or1k_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-029 Read buffer SHALL be sub-module peripheral_dbg_pu_or1k_fifo (DW, FIFO_DEPTH params).

Verification
REQ-030 Write burst addr=0x2800, len=3, incr=1, data 0xA..0xD, ack 1 cycle -> four stb pulses at 0x2800..0x2803 with matching data, one done_o, err_o 0.
REQ-031 Read burst addr=0x1000, len=9, incr=0, rdata_ready_i=0 -> 8 acks, stb held off, busy_o 1; then drain -> remaining 2 words, 10 words total, all from 0x1000.
REQ-032 Zero-wait ack (ack high in first ACCESS cycle) on read len=0 -> single-cycle stb, FIFO holds cpu_data_i, done_o 1 cycle later.
REQ-033 TIMEOUT=4, no ack -> stb high exactly 4 cycles, err_o 1, done_o pulse, FIFO empty; ack on 4th cycle variant -> no error.
REQ-034 Address wrap: addr=0xFFFFFFFF, len=1, incr=1 -> accesses at 0xFFFFFFFF then 0x00000000.
REQ-035 rst_i asserted during ACCESS of 3rd word -> stb 0 immediately, FIFO empty, cmd_ready_o 1 after release.

Source files
------------

// File: rtl/peripheral_dbg_pu_or1k_pkg.sv
// Shared types and default parameters for the OR1K debug-unit SPR burst engine.
package peripheral_dbg_pu_or1k_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int unsigned DEF_AW         = 32;
    localparam int unsigned DEF_DW         = 32;
    localparam int unsigned DEF_LEN_W      = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 8;
    localparam int unsigned DEF_TIMEOUT    = 255;

endpackage

// File: rtl/peripheral_dbg_pu_or1k_fifo.sv
// Read-data buffer: power-of-two synchronous FIFO, push and pop allowed together even when full.
module peripheral_dbg_pu_or1k_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          empty,
    output logic          full
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push_ok, pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(DEPTH));
    // a pop on the same edge frees the slot the push needs
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/peripheral_dbg_pu_or1k_burst.sv
// Debug-unit burst engine: turns one command into a sequence of SPR bus accesses,
// streaming write words in and buffering read words in a FIFO.
module peripheral_dbg_pu_or1k_burst
    import peripheral_dbg_pu_or1k_pkg::*;
#(
    parameter int unsigned AW         = DEF_AW,
    parameter int unsigned DW         = DEF_DW,
    parameter int unsigned LEN_W      = DEF_LEN_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             cpu_clk_i,
    input  logic             rst_i,

    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [AW-1:0]    cmd_addr_i,
    input  logic             cmd_we_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             cmd_incr_i,

    input  logic             wdata_valid_i,
    output logic             wdata_ready_o,
    input  logic [DW-1:0]    wdata_i,

    output logic             rdata_valid_o,
    input  logic             rdata_ready_i,
    output logic [DW-1:0]    rdata_o,

    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,

    output logic [AW-1:0]    cpu_addr_o,
    output logic [DW-1:0]    cpu_data_o,
    input  logic [DW-1:0]    cpu_data_i,
    output logic             cpu_stb_o,
    output logic             cpu_we_o,
    input  logic             cpu_ack_i
);

    localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    state_t           state, state_nxt;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdat_q;
    logic [LEN_W-1:0] remain_q;
    logic [CNT_W-1:0] acc_cnt;
    logic             we_q, incr_q, done_q, err_q;

    logic cmd_acc, wr_hs, ack, tmo, last;
    logic fifo_push, fifo_pop, fifo_empty, fifo_full;

    assign cmd_acc = cmd_valid_i && (state == IDLE);
    assign wr_hs   = (state == ISSUE) && we_q && wdata_valid_i;
    assign ack     = (state == ACCESS) && cpu_ack_i;
    assign last    = (remain_q == '0);
    // an ack on the final counted cycle wins over the timeout
    assign tmo     = (TIMEOUT != 0) && (state == ACCESS) && !cpu_ack_i
                     && (acc_cnt == CNT_W'(TO_LAST));

    always_ff @(posedge cpu_clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid_i) state_nxt = ISSUE;
            ISSUE:   if (we_q ? wdata_valid_i : !fifo_full) state_nxt = ACCESS;
            ACCESS: begin
                if (ack)      state_nxt = last ? IDLE : ISSUE;
                else if (tmo) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q   <= '0;
            wdat_q   <= '0;
            remain_q <= '0;
            acc_cnt  <= '0;
            we_q     <= 1'b0;
            incr_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= (ack && last) || tmo;
            if (cmd_acc) begin
                addr_q   <= cmd_addr_i;
                we_q     <= cmd_we_i;
                incr_q   <= cmd_incr_i;
                remain_q <= cmd_len_i;
                err_q    <= 1'b0;
            end
            if (wr_hs) wdat_q <= wdata_i;
            if (ack) begin
                if (incr_q) addr_q <= addr_q + AW'(1);
                if (!last)  remain_q <= remain_q - LEN_W'(1);
            end
            if (tmo) err_q <= 1'b1;
            if ((state == ACCESS) && !ack && !tmo) acc_cnt <= acc_cnt + CNT_W'(1);
            else                                   acc_cnt <= '0;
        end
    end

    assign fifo_push = ack && !we_q;
    assign fifo_pop  = rdata_ready_i;

    peripheral_dbg_pu_or1k_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk       (cpu_clk_i),
        .rst       (rst_i),
        .push      (fifo_push),
        .push_data (cpu_data_i),
        .pop       (fifo_pop),
        .pop_data  (rdata_o),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign cmd_ready_o   = (state == IDLE);
    assign wdata_ready_o = (state == ISSUE) && we_q;
    assign rdata_valid_o = !fifo_empty;
    assign busy_o        = (state != IDLE);
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign cpu_stb_o     = (state == ACCESS);
    assign cpu_addr_o    = addr_q;
    assign cpu_we_o      = we_q;
    assign cpu_data_o    = wdat_q;

endmodule

// File: tb/tb_peripheral_dbg_pu_or1k_burst.sv
// Directed self-checking bench for the SPR burst engine with a latency-configurable bus responder.
module tb_peripheral_dbg_pu_or1k_burst;

    logic        cpu_clk_i;
    logic        rst_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i, cmd_incr_i;
    logic [31:0] cmd_addr_i;
    logic [15:0] cmd_len_i;
    logic        wdata_valid_i, wdata_ready_o;
    logic [31:0] wdata_i;
    logic        rdata_valid_o, rdata_ready_i;
    logic [31:0] rdata_o;
    logic        busy_o, done_o, err_o;
    logic [31:0] cpu_addr_o, cpu_data_o, cpu_data_i;
    logic        cpu_stb_o, cpu_we_o, cpu_ack_i;

    peripheral_dbg_pu_or1k_burst #(
        .AW         (32),
        .DW         (32),
        .LEN_W      (16),
        .FIFO_DEPTH (8),
        .TIMEOUT    (4)
    ) dut (
        .cpu_clk_i     (cpu_clk_i),
        .rst_i         (rst_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_we_i      (cmd_we_i),
        .cmd_len_i     (cmd_len_i),
        .cmd_incr_i    (cmd_incr_i),
        .wdata_valid_i (wdata_valid_i),
        .wdata_ready_o (wdata_ready_o),
        .wdata_i       (wdata_i),
        .rdata_valid_o (rdata_valid_o),
        .rdata_ready_i (rdata_ready_i),
        .rdata_o       (rdata_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .cpu_addr_o    (cpu_addr_o),
        .cpu_data_o    (cpu_data_o),
        .cpu_data_i    (cpu_data_i),
        .cpu_stb_o     (cpu_stb_o),
        .cpu_we_o      (cpu_we_o),
        .cpu_ack_i     (cpu_ack_i)
    );

    initial cpu_clk_i = 1'b0;
    always #5 cpu_clk_i = ~cpu_clk_i;

    int tests_run    = 0;
    int tests_failed = 0;

    int  ack_lat   = 0;
    bit  ack_en    = 1'b1;
    bit  ack_force = 1'b0;
    int  wcnt      = 0;
    int  rd_seq    = 0;
    int  stb_cycles  = 0;
    int  done_cycles = 0;

    logic [31:0] log_addr [$];
    bit          log_we   [$];
    logic [31:0] log_data [$];
    logic [31:0] wq [$];
    logic [31:0] rx [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus responder, write-data source and read-data sink: sample on the edge, drive 1 time unit later.
    always @(posedge cpu_clk_i) begin
        if (!rst_i) begin
            if (cpu_stb_o) stb_cycles++;
            if (done_o) done_cycles++;
            if (cpu_stb_o && cpu_ack_i) begin
                log_addr.push_back(cpu_addr_o);
                log_we.push_back(cpu_we_o);
                log_data.push_back(cpu_we_o ? cpu_data_o : cpu_data_i);
                if (!cpu_we_o) rd_seq++;
            end
            if (wdata_valid_i && wdata_ready_o) void'(wq.pop_front());
            if (rdata_valid_o && rdata_ready_i) rx.push_back(rdata_o);
        end
        #1;
        if (cpu_stb_o) begin
            cpu_ack_i = ack_en && (wcnt >= ack_lat);
            wcnt++;
        end else begin
            cpu_ack_i = ack_force;
            wcnt = 0;
        end
        cpu_data_i    = 32'hD000_0000 + 32'(rd_seq);
        wdata_valid_i = (wq.size() > 0);
        wdata_i       = (wq.size() > 0) ? wq[0] : 32'h0;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge cpu_clk_i);
            #2;
        end
    endtask

    task automatic clear_stats();
        stb_cycles  = 0;
        done_cycles = 0;
        rd_seq      = 0;
        log_addr.delete();
        log_we.delete();
        log_data.delete();
        rx.delete();
    endtask

    task automatic send_cmd(input logic [31:0] a, input logic we, input logic [15:0] len, input logic incr);
        @(negedge cpu_clk_i);
        cmd_addr_i  = a;
        cmd_we_i    = we;
        cmd_len_i   = len;
        cmd_incr_i  = incr;
        cmd_valid_i = 1'b1;
        check("cmd_ready_before_accept", cmd_ready_o, 1);
        @(posedge cpu_clk_i);
        #2;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, busy_o, 0);
    endtask

    task automatic wait_log(input string tag, input int cnt, input int budget);
        int n = 0;
        while (log_addr.size() < cnt && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, log_addr.size(), cnt);
    endtask

    task automatic drain();
        rdata_ready_i = 1'b1;
        tick(10);
        rdata_ready_i = 1'b0;
        check("drain_empty", rdata_valid_o, 0);
        rx.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_we_i = 1'b0; cmd_len_i = '0; cmd_incr_i = 1'b0;
        rdata_ready_i = 1'b0;
        cpu_ack_i = 1'b0; cpu_data_i = '0; wdata_valid_i = 1'b0; wdata_i = '0;
        tick(2);
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_stb", cpu_stb_o, 0);
        check("rst_we", cpu_we_o, 0);
        check("rst_addr", cpu_addr_o, 0);
        check("rst_wdata", cpu_data_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_rvalid", rdata_valid_o, 0);
        check("rst_rdata", rdata_o, 0);
        @(negedge cpu_clk_i);
        rst_i = 1'b0;
        tick(1);

        // ack outside ACCESS must do nothing
        clear_stats();
        ack_force = 1'b1;
        tick(3);
        ack_force = 1'b0;
        tick(1);
        check("idle_ack_busy", busy_o, 0);
        check("idle_ack_done", done_cycles, 0);
        check("idle_ack_fifo", rdata_valid_o, 0);

        // write burst, one wait state per word
        clear_stats();
        ack_lat = 1;
        wq.push_back(32'hA); wq.push_back(32'hB); wq.push_back(32'hC); wq.push_back(32'hD);
        send_cmd(32'h2800, 1'b1, 16'd3, 1'b1);
        wait_idle("wr_idle", 60);
        tick(2);
        check("wr_count", log_addr.size(), 4);
        for (int i = 0; i < log_addr.size() && i < 4; i++) begin
            check($sformatf("wr_addr%0d", i), log_addr[i], 32'h2800 + 32'(i));
            check($sformatf("wr_data%0d", i), log_data[i], 32'hA + 32'(i));
            check($sformatf("wr_we%0d", i), log_we[i], 1);
        end
        check("wr_stb_cycles", stb_cycles, 8);
        check("wr_done", done_cycles, 1);
        check("wr_err", err_o, 0);
        check("wr_wq_used", wq.size(), 0);

        // read burst into a stalled FIFO, then drain
        clear_stats();
        ack_lat = 0;
        send_cmd(32'h1000, 1'b0, 16'd9, 1'b0);
        wait_log("rd_fill", 8, 100);
        tick(5);
        check("rd_stalled_count", log_addr.size(), 8);
        check("rd_stalled_stb", cpu_stb_o, 0);
        check("rd_stalled_stb_cycles", stb_cycles, 8);
        check("rd_stalled_busy", busy_o, 1);
        check("rd_stalled_rvalid", rdata_valid_o, 1);
        rdata_ready_i = 1'b1;
        wait_idle("rd_idle", 100);
        tick(12);
        rdata_ready_i = 1'b0;
        check("rd_total", log_addr.size(), 10);
        check("rd_rx_total", rx.size(), 10);
        for (int i = 0; i < log_addr.size(); i++)
            check($sformatf("rd_addr%0d", i), log_addr[i], 32'h1000);
        for (int i = 0; i < rx.size(); i++)
            check($sformatf("rd_data%0d", i), rx[i], 32'hD000_0000 + 32'(i));
        check("rd_done", done_cycles, 1);
        check("rd_err", err_o, 0);
        check("rd_empty", rdata_valid_o, 0);
        rx.delete();

        // zero-wait single read: exact cycle timing
        clear_stats();
        ack_lat = 0;
        send_cmd(32'h40, 1'b0, 16'd0, 1'b0);
        check("zw_issue_stb", cpu_stb_o, 0);
        tick(1);
        check("zw_access_stb", cpu_stb_o, 1);
        check("zw_access_done", done_o, 0);
        tick(1);
        check("zw_after_stb", cpu_stb_o, 0);
        check("zw_after_done", done_o, 1);
        check("zw_after_busy", busy_o, 0);
        tick(1);
        check("zw_done_cleared", done_o, 0);
        check("zw_stb_cycles", stb_cycles, 1);
        check("zw_rvalid", rdata_valid_o, 1);
        check("zw_rdata", rdata_o, 32'hD000_0000);
        drain();

        // timeout with no ack
        clear_stats();
        ack_en = 1'b0;
        send_cmd(32'h300, 1'b0, 16'd2, 1'b1);
        wait_idle("to_idle", 50);
        tick(2);
        ack_en = 1'b1;
        check("to_stb_cycles", stb_cycles, 4);
        check("to_err", err_o, 1);
        check("to_done", done_cycles, 1);
        check("to_fifo", rdata_valid_o, 0);
        check("to_acks", log_addr.size(), 0);

        // ack on the last permitted cycle
        clear_stats();
        ack_lat = 3;
        send_cmd(32'h304, 1'b0, 16'd0, 1'b0);
        check("to4_err_cleared", err_o, 0);
        wait_idle("to4_idle", 50);
        tick(2);
        check("to4_stb_cycles", stb_cycles, 4);
        check("to4_err", err_o, 0);
        check("to4_done", done_cycles, 1);
        check("to4_rvalid", rdata_valid_o, 1);
        check("to4_rdata", rdata_o, 32'hD000_0000);
        drain();

        // address wrap
        clear_stats();
        ack_lat = 0;
        send_cmd(32'hFFFF_FFFF, 1'b0, 16'd1, 1'b1);
        wait_idle("wrap_idle", 50);
        tick(2);
        check("wrap_count", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("wrap_addr0", log_addr[0], 32'hFFFF_FFFF);
            check("wrap_addr1", log_addr[1], 32'h0);
        end
        drain();

        // reset during the third word's access
        clear_stats();
        ack_lat = 1;
        send_cmd(32'h500, 1'b0, 16'd5, 1'b1);
        begin
            int n = 0;
            while (!(log_addr.size() == 2 && cpu_stb_o) && n < 50) begin
                tick(1);
                n++;
            end
        end
        check("rstmid_in_access", cpu_stb_o, 1);
        check("rstmid_addr", cpu_addr_o, 32'h502);
        check("rstmid_fifo_before", rdata_valid_o, 1);
        #1 rst_i = 1'b1;
        #1;
        check("rstmid_stb", cpu_stb_o, 0);
        check("rstmid_busy", busy_o, 0);
        check("rstmid_fifo", rdata_valid_o, 0);
        check("rstmid_rdata", rdata_o, 0);
        @(negedge cpu_clk_i);
        rst_i = 1'b0;
        tick(1);
        check("rstmid_cmd_ready", cmd_ready_o, 1);
        check("rstmid_fifo_after", rdata_valid_o, 0);
        check("rstmid_addr_after", cpu_addr_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
